// File: rtl/serial_cmp_pkg.sv
// Shared types and parameter limits for the MSB-first serial comparator front end.
package serial_cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_pair_serializer_msb_first_if.sv
// Word-pair handshake in, bit-serial pair plus framing out.
interface serial_pair_serializer_msb_first_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic             cmp_clear;
   logic             a;
   logic             b;
   logic             bit_valid;
   logic             first_bit;
   logic             last_bit;

   modport master (
      output in_valid, a_word, b_word,
      input  in_ready, cmp_clear, a, b, bit_valid, first_bit, last_bit
   );

   modport slave (
      input  in_valid, a_word, b_word,
      output in_ready, cmp_clear, a, b, bit_valid, first_bit, last_bit
   );

endinterface

// File: rtl/serial_pair_serializer_msb_first_shift.sv
// Loadable left-shift register presenting its MSB; shifts in zeros from the LSB end.
module msb_first_shift_register #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// Accepts an A/B word pair, pulses a comparator clear, then streams both words MSB first.
module serial_pair_serializer_msb_first
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                               clk,
   input logic                               rst,
   serial_pair_serializer_msb_first_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_pair_serializer_msb_first: WIDTH out of range");
   end

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic             ready;
   logic             accept;
   logic             shifting;
   logic             load_en;
   logic [WIDTH-1:0] a_load;
   logic [WIDTH-1:0] b_load;
   logic             a_msb;
   logic             b_msb;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (bus.in_valid) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt == '0) begin
               ready     = 1'b1;
               state_nxt = bus.in_valid ? ST_CLEAR : ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept   = bus.in_valid & ready;
   assign shifting = (state == ST_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= CW'(WIDTH - 1);
         end else if (shifting && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // NOTE: the shift registers have no reset port; reset clears them by forcing a load of zeros.
   assign load_en = rst | accept;
   assign a_load  = rst ? '0 : bus.a_word;
   assign b_load  = rst ? '0 : bus.b_word;

   msb_first_shift_register #(.WIDTH(WIDTH)) u_shift_a (
      .clk   (clk),
      .load  (load_en),
      .shift (shifting),
      .d     (a_load),
      .msb   (a_msb)
   );

   msb_first_shift_register #(.WIDTH(WIDTH)) u_shift_b (
      .clk   (clk),
      .load  (load_en),
      .shift (shifting),
      .d     (b_load),
      .msb   (b_msb)
   );

   assign bus.in_ready  = ready;
   assign bus.cmp_clear = (state == ST_CLEAR);
   assign bus.bit_valid = shifting;
   assign bus.a         = shifting & a_msb;
   assign bus.b         = shifting & b_msb;
   assign bus.first_bit = shifting && (cnt == CW'(WIDTH - 1));
   assign bus.last_bit  = shifting && (cnt == '0);

endmodule
